pipeline_stage_skid: RTL

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It is the successor to the fixed-width write-enable/flush stage registers. Stall becomes backpressure (`out_ready_i`), and flush inserts a configurable bubble value. It sits between any two CPU pipeline stages (IF/ID, ID/EX, …) and holds full throughput while keeping `in_ready_o` free of any combinational path from `out_ready_i`.

---
 rtl/pipeline_stage_skid.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipeline_stage_skid.sv
// ---------------------------------------------------------------------------
// pipeline_stage_skid
//   Pipeline stage register with a valid/ready handshake and a one-entry skid
//   buffer. Holds full throughput while in_ready_o is a pure decode of the
//   state register, so it has no combinational path from out_ready_i.
//
// Parameters
//   DATA_W      payload width
//   BUBBLE_VAL  value driven on out_data_o while the stage is empty
//
// Ports
//   clk_i        clock, all state updates on posedge
//   rst_i        synchronous active-high reset
//   flush_i      discard all held entries at the next posedge
//   in_valid_i   upstream offers in_data_i
//   in_data_i    upstream payload
//   in_ready_o   stage accepts input this cycle (state decode)
//   out_valid_o  out_data_o holds a valid entry
//   out_data_o   head entry, or BUBBLE_VAL when empty
//   out_ready_i  downstream consumes the head this cycle
//   count_o      number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipeline_stage_skid #(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        count_o
);

    // Encoding equals the number of held entries, so count_o is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [DATA_W-1:0] main_q,  main_n;
    logic [DATA_W-1:0] skid_q,  skid_n;
    logic              acc, pop;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign count_o     = state_q;

    assign acc = in_valid_i & in_ready_o;
    assign pop = out_valid_o & out_ready_i;

    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    main_n  = in_data_i;
                    state_n = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    main_n = in_data_i;
                end else if (acc) begin
                    skid_n  = in_data_i;
                    state_n = FULL;
                end else if (pop) begin
                    main_n  = BUBBLE_VAL;
                    state_n = EMPTY;
                end
            end
            FULL: begin
                // No acc possible here: in_ready_o is low while FULL.
                if (pop) begin
                    main_n  = skid_q;
                    state_n = ONE;
                end
            end
            default: begin
                main_n  = BUBBLE_VAL;
                state_n = EMPTY;
            end
        endcase
        // Flush overrides any transfer; a pop this cycle still counts for the
        // consumer because the head was valid when it was sampled.
        if (flush_i) begin
            main_n  = BUBBLE_VAL;
            state_n = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_n;
            main_q  <= main_n;
        end
    end

    // Skid contents are only read while FULL, so they need no reset.
    always_ff @(posedge clk_i) begin
        skid_q <= skid_n;
    end

endmodule
